// File: rtl/synth_voice_allocator.sv
// Polyphony controller: maps note events onto synth voices and
// sequences the resulting register writes onto the synth write bus.
module synth_voice_allocator #(
  parameter int NUMVOICES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ev_valid,
  output logic                 ev_ready,
  input  logic [1:0]           ev_cmd,
  input  logic [1:0]           ev_group,
  input  logic [6:0]           ev_key,
  input  logic [15:0]          ev_increment,
  output logic [7:0]           syn_addr,
  output logic [31:0]          syn_data,
  output logic                 syn_wen,
  input  logic                 syn_ready,
  output logic [NUMVOICES-1:0] voices_active,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE,
    ALLOC,
    WRITE,
    GAP
  } state_t;

  localparam logic [1:0] CMD_OFF = 2'd0;
  localparam logic [1:0] CMD_ON  = 2'd1;
  localparam logic [1:0] CMD_ALL = 2'd2;

  state_t state, state_n;

  logic [1:0]  cmd_q, grp_q;
  logic [6:0]  key_q;
  logic [15:0] inc_q;

  logic [NUMVOICES-1:0] active;
  logic [6:0]           keys [NUMVOICES];
  logic                 p0, p1;
  logic [1:0]           p2;
  logic [2:0]           p3;

  logic [39:0] wl [4];
  logic [1:0]  wl_len, wl_idx;

  logic [NUMVOICES-1:0] mask;
  logic [2:0]  steal_v, hit_v, free_v, off_v, vsel;
  logic        hit, free, off;
  logic        do_steal;
  logic [1:0]  n_len;
  logic [39:0] n_w [4];

  function automatic logic [39:0] w_inc(logic [2:0] v, logic [15:0] inc);
    return {1'b0, v, 4'h0, 16'h0000, inc};
  endfunction

  function automatic logic [39:0] w_gate(logic [2:0] v, logic on);
    return {1'b0, v, 4'hC, 31'h0, on};
  endfunction

  // Voice selection and write-list construction for the latched event
  always_comb begin
    mask    = '0;
    steal_v = 3'd0;
    unique case (grp_q)
      2'd0: begin mask = 8'h03; steal_v = {2'b00, p0}; end
      2'd1: begin mask = 8'h0C; steal_v = {2'b01, p1}; end
      2'd2: begin mask = 8'hF0; steal_v = {1'b1, p2}; end
      default: begin mask = 8'hFF; steal_v = p3; end
    endcase
    hit    = 1'b0;
    free   = 1'b0;
    off    = 1'b0;
    hit_v  = 3'd0;
    free_v = 3'd0;
    off_v  = 3'd0;
    for (int i = NUMVOICES - 1; i >= 0; i--) begin
      if (active[i] && keys[i] == key_q) begin
        off   = 1'b1;
        off_v = 3'(i);
        if (mask[i]) begin
          hit   = 1'b1;
          hit_v = 3'(i);
        end
      end
      if (mask[i] && !active[i]) begin
        free   = 1'b1;
        free_v = 3'(i);
      end
    end
    vsel     = steal_v;
    do_steal = 1'b0;
    n_len    = 2'd0;
    for (int i = 0; i < 4; i++) n_w[i] = '0;
    unique case (cmd_q)
      CMD_ON: begin
        unique case (1'b1)
          hit: begin
            vsel  = hit_v;
            n_len = 2'd3;
          end
          !hit && free: begin
            vsel  = free_v;
            n_len = 2'd2;
          end
          default: begin
            do_steal = 1'b1;
            n_len    = 2'd3;
          end
        endcase
        if (n_len == 2'd2) begin
          n_w[0] = w_inc(vsel, inc_q);
          n_w[1] = w_gate(vsel, 1'b1);
        end else begin
          n_w[0] = w_gate(vsel, 1'b0);
          n_w[1] = w_inc(vsel, inc_q);
          n_w[2] = w_gate(vsel, 1'b1);
        end
      end
      CMD_OFF: begin
        if (off) begin
          n_len  = 2'd1;
          n_w[0] = w_gate(off_v, 1'b0);
        end
      end
      CMD_ALL: begin
        n_len  = 2'd1;
        n_w[0] = {8'hF4, 32'h0};
      end
      default: n_len = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (ev_valid) state_n = ALLOC;
      ALLOC: state_n = (n_len != 2'd0) ? WRITE : IDLE;
      WRITE: if (syn_ready) state_n = GAP;
      GAP:   state_n = (wl_idx < wl_len) ? WRITE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= '0;
      p0       <= 1'b0;
      p1       <= 1'b0;
      p2       <= 2'd0;
      p3       <= 3'd0;
      syn_addr <= '0;
      syn_data <= '0;
      wl_len   <= 2'd0;
      wl_idx   <= 2'd0;
    end else begin
      if (state == IDLE && ev_valid) begin
        cmd_q <= ev_cmd;
        grp_q <= ev_group;
        key_q <= ev_key;
        inc_q <= ev_increment;
      end
      if (state == ALLOC) begin
        unique case (cmd_q)
          CMD_ON: begin
            active[vsel] <= 1'b1;
            keys[vsel]   <= key_q;
            if (do_steal) begin
              unique case (grp_q)
                2'd0: p0 <= ~p0;
                2'd1: p1 <= ~p1;
                2'd2: p2 <= p2 + 2'd1;
                default: p3 <= p3 + 3'd1;
              endcase
            end
          end
          CMD_OFF: if (off) active[off_v] <= 1'b0;
          CMD_ALL: begin
            active <= '0;
            p0     <= 1'b0;
            p1     <= 1'b0;
            p2     <= 2'd0;
            p3     <= 3'd0;
          end
          default: ;
        endcase
        for (int i = 0; i < 4; i++) wl[i] <= n_w[i];
        wl_len <= n_len;
        wl_idx <= 2'd0;
        if (n_len != 2'd0) begin
          syn_addr <= n_w[0][39:32];
          syn_data <= n_w[0][31:0];
        end
      end
      if (state == WRITE && syn_ready) wl_idx <= wl_idx + 2'd1;
      if (state == GAP && wl_idx < wl_len) begin
        syn_addr <= wl[wl_idx][39:32];
        syn_data <= wl[wl_idx][31:0];
      end
    end
  end

  assign ev_ready      = (state == IDLE) && !rst;
  assign syn_wen       = (state == WRITE);
  assign busy          = (state != IDLE);
  assign voices_active = active;

endmodule

// File: doc/synth_voice_allocator.md
# synth_voice_allocator

Polyphony controller in front of `synth_interface`. It accepts note-on, note-off and all-off events from the CPU-side event port, assigns each note to a free voice of the requested timbre group, and steals a voice round-robin when the group is full. It then sequences the resulting register writes onto the synth's write bus (`addr`/`data_in`/`wen`/`ready`). It sits between the CPU event register (or a MIDI parser) and `synth_interface`.

## Interface
- `NUMVOICES`, 8: voices managed. The group map below is fixed for 8.
- `clk` in 1: system clock (48 MHz).
- `rst` in 1: synchronous, active-high reset.
- `ev_valid` in 1: event present.
- `ev_ready` out 1: event accepted on `ev_valid && ev_ready`.
- `ev_cmd` in 2: event command. 0 note-off, 1 note-on, 2 all-off, 3 reserved.
- `ev_group` in 2: timbre group. 0 saw (voices 0-1), 1 pulse (2-3), 2 triangle (4-7), 3 any (0-7).
- `ev_key` in 7: note identifier, used to match note-off to note-on.
- `ev_increment` in 16: pitch increment for note-on.
- `syn_addr` out 8: synth register address.
- `syn_data` out 32: synth write data.
- `syn_wen` out 1: write strobe to synth.
- `syn_ready` in 1: write acknowledge from synth.
- `voices_active` out 8: allocation table, bit v = voice v allocated.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- **Voice table:** per voice, an `active` bit and a 7-bit `key`. Per group, a steal pointer: 1 bit for groups 0 and 1, 2 bits for group 2, 3 bits for group 3.
- **States:** IDLE, ALLOC, WRITE, GAP.
  - IDLE: `ev_ready`=1. On accept, latch the event fields and go to ALLOC.
  - ALLOC: one cycle. Select the voice, update the table, build a write list of 0–3 entries.
  - WRITE: drive `syn_wen`=1 with stable addr/data until `syn_ready` is sampled 1. Then go to GAP.
  - GAP: `syn_wen`=0 for exactly one cycle. Go to WRITE if list entries remain, otherwise IDLE.
  - An empty write list goes from ALLOC straight to IDLE.
- **Note-on, key already active in group:** reuse the lowest-index voice holding that key. Writes: gate-off, increment, gate-on.
- **Note-on, free voice in group:** take the lowest-index inactive voice v. Writes: increment, gate-on.
- **Note-on, group full:** steal the voice at the group's steal pointer, then advance the pointer, wrapping within the group. Writes: gate-off, increment, gate-on.
- **Table update on note-on:** `active[v]`=1, `key[v]`=`ev_key`.
- **Note-off:** find the lowest-index active voice, any group, with matching key. Clear `active[v]` and write gate-off. With no match: no write, event consumed.
- **All-off:** clear all `active` bits and reset the steal pointers to 0. Write addr 8'hF4, data 0.
- **cmd 3:** consumed, no write, table unchanged.
- **Write encodings** (v = voice index, 3 bits):
  - increment: addr {1'b0,v,4'h0}, data {16'h0000, ev_increment}. The zero duration leaves the gate untouched.
  - gate-on: addr {1'b0,v,4'hC}, data 32'h1.
  - gate-off: addr {1'b0,v,4'hC}, data 32'h0.
- **Group 3 steal pointer:** independent of the group 0–2 pointers. Steals voice 0..7 in order.
- **Reset:**
  - outputs: `ev_ready`=0 during reset, `syn_wen`=0, `syn_addr`=0, `syn_data`=0, `voices_active`=0, `busy`=0.
  - internal: pointers 0, state IDLE.
  - Reset during WRITE drops `syn_wen` on the next edge. The pending write list is discarded.

## Timing
- Event accepted at edge 0; ALLOC during cycle 1; `syn_wen` rises at edge 2.
- `voices_active` reflects the new allocation from edge 2.
- With the synth's one-cycle ack, `syn_ready` is high in cycle 3 and `syn_wen` is low in cycle 4 (GAP).
- Total occupancy from accept to `ev_ready` back high is 2 + 3·N cycles for N writes:
  - free-voice note-on: 8 cycles;
  - steal: 11;
  - note-off or all-off: 5;
  - no-op: 2.
- `syn_addr`/`syn_data` change only on entry to WRITE. They hold their last value in GAP and IDLE.
- No write is ever presented for fewer than 1 cycle or repeated after ack.
- `syn_ready` while `syn_wen`=0 is ignored.
- A write stalls indefinitely without `syn_ready`; there is no timeout.

## Test plan
- **Note-on, free voice:** reset, then note-on group 2, key 60, inc 16'h0C00 → writes (8'h40, 32'h00000C00), then (8'h4C, 32'h1). `voices_active`=8'h10. `ev_ready` high again 8 cycles after accept.
- **Steal:** three note-ons in group 0, keys 1, 2, 3 → third steals voice 0 with writes 8'h0C/0, 8'h00/inc, 8'h0C/1. `voices_active`=8'h03. Fourth note-on steals voice 1.
- **Note-off:** note-off key 2 after the previous scenario → single write (8'h1C, 0) and bit 1 clears. Note-off key 99 → no `syn_wen`; `ev_ready` returns after 2 cycles.
- **All-off:** all-off with 5 voices active → one write (8'hF4, 0). `voices_active`=0. Next group-0 note-on lands on voice 0.
- **Handshake:** hold `syn_ready` low for 10 cycles during a write → `syn_wen`, addr and data stable throughout. Exactly one GAP cycle after ack.
- **Reset mid-write:** assert `rst` while `syn_wen`=1 → `syn_wen`=0 and `voices_active`=0 after the edge. No further writes are issued.
